// File: rtl/fifo_level_if.sv
// Handshake/status bundle between a producer/consumer and the fifo_level buffer.
interface fifo_level_if #(
    parameter int unsigned B = 8,
    parameter int unsigned W = 4
);
    logic         wr;
    logic         rd;
    logic [B-1:0] w_data;
    logic         flush;
    logic         clr_err;
    logic [B-1:0] r_data;
    logic [W:0]   count;
    logic         full;
    logic         empty;
    logic         almost_full;
    logic         almost_empty;
    logic         overflow;
    logic         underflow;

    // Side that pushes/pops and watches the status flags
    modport master (
        output wr, rd, w_data, flush, clr_err,
        input  r_data, count, full, empty, almost_full, almost_empty, overflow, underflow
    );

    // The FIFO itself
    modport slave (
        input  wr, rd, w_data, flush, clr_err,
        output r_data, count, full, empty, almost_full, almost_empty, overflow, underflow
    );
endinterface

// File: rtl/fifo_level.sv
// Synchronous show-ahead FIFO with occupancy count, almost-full/empty thresholds,
// synchronous flush and sticky overflow/underflow flags. All status is registered.
module fifo_level #(
    parameter int unsigned B        = 8,
    parameter int unsigned W        = 4,
    parameter int unsigned AF_LEVEL = (1 << W) - 1,
    parameter int unsigned AE_LEVEL = 1
) (
    input logic        clk,
    input logic        reset,
    fifo_level_if.slave bus
);
    localparam int unsigned D      = 1 << W;
    localparam logic [W:0]  DCnt   = (W + 1)'(D);
    localparam logic [W:0]  AfCnt  = (W + 1)'(AF_LEVEL);
    localparam logic [W:0]  AeCnt  = (W + 1)'(AE_LEVEL);
    localparam logic [W:0]  CntOne = (W + 1)'(1);
    localparam logic [W-1:0] PtrOne = W'(1);

    logic [B-1:0] mem [D];

    logic [W-1:0] w_ptr_q, w_ptr_d;
    logic [W-1:0] r_ptr_q, r_ptr_d;
    logic [W:0]   count_q, count_d;
    logic         full_q, full_d;
    logic         empty_q, empty_d;
    logic         af_q, af_d;
    logic         ae_q, ae_d;
    logic         ovf_q, ovf_d;
    logic         udf_q, udf_d;
    logic         wr_ok, rd_ok;

    // Accept decisions and next state, all from pre-edge registered state
    always_comb begin
        // A pop in the same cycle frees the slot, so a write to a full FIFO still lands
        wr_ok   = bus.wr && (!full_q || bus.rd);
        rd_ok   = bus.rd && !empty_q;
        w_ptr_d = w_ptr_q;
        r_ptr_d = r_ptr_q;
        count_d = count_q;
        if (bus.flush) begin
            w_ptr_d = '0;
            r_ptr_d = '0;
            count_d = '0;
        end else begin
            if (wr_ok) w_ptr_d = w_ptr_q + PtrOne;
            if (rd_ok) r_ptr_d = r_ptr_q + PtrOne;
            if (wr_ok && !rd_ok) begin
                count_d = count_q + CntOne;
            end else if (!wr_ok && rd_ok) begin
                count_d = count_q - CntOne;
            end
        end
        full_d  = (count_d == DCnt);
        empty_d = (count_d == '0);
        af_d    = (count_d >= AfCnt);
        ae_d    = (count_d <= AeCnt);
        // Setting wins over clearing; flush suppresses both error sources
        ovf_d = (bus.wr && full_q && !bus.rd && !bus.flush) || (ovf_q && !bus.clr_err);
        udf_d = (bus.rd && empty_q && !bus.flush) || (udf_q && !bus.clr_err);
    end

    // Pointer, count, flag and error registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            w_ptr_q <= '0;
            r_ptr_q <= '0;
            count_q <= '0;
            full_q  <= 1'b0;
            empty_q <= 1'b1;
            af_q    <= 1'b0;
            ae_q    <= 1'b1;
            ovf_q   <= 1'b0;
            udf_q   <= 1'b0;
        end else begin
            w_ptr_q <= w_ptr_d;
            r_ptr_q <= r_ptr_d;
            count_q <= count_d;
            full_q  <= full_d;
            empty_q <= empty_d;
            af_q    <= af_d;
            ae_q    <= ae_d;
            ovf_q   <= ovf_d;
            udf_q   <= udf_d;
        end
    end

    // Storage array, deliberately not reset
    always_ff @(posedge clk) begin
        if (wr_ok && !bus.flush) mem[w_ptr_q] <= bus.w_data;
    end

    assign bus.r_data       = mem[r_ptr_q];
    assign bus.count        = count_q;
    assign bus.full         = full_q;
    assign bus.empty        = empty_q;
    assign bus.almost_full  = af_q;
    assign bus.almost_empty = ae_q;
    assign bus.overflow     = ovf_q;
    assign bus.underflow    = udf_q;
endmodule

// File: tb/tb_fifo_level.sv
// Directed bench for fifo_level with B=8, W=2, AF_LEVEL=3, AE_LEVEL=1.
module tb_fifo_level;
    logic clk;
    logic reset;
    int   checks;
    int   failures;

    fifo_level_if #(.B(8), .W(2)) bus ();

    fifo_level #(
        .B(8),
        .W(2),
        .AF_LEVEL(3),
        .AE_LEVEL(1)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       wr;
        logic       rd;
        logic       flush;
        logic       clr;
        logic [7:0] wd;
        logic [2:0] cnt;
        logic       f;
        logic       e;
        logic       af;
        logic       ae;
        logic       ov;
        logic       ud;
        logic       chk_rd;
        logic [7:0] rdat;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic wr, input logic rd, input logic flush,
                                input logic clr, input logic [7:0] wd, input logic [2:0] cnt,
                                input logic f, input logic e, input logic af, input logic ae,
                                input logic ov, input logic ud, input logic chk_rd,
                                input logic [7:0] rdat);
        vec_t v;
        v.wr = wr; v.rd = rd; v.flush = flush; v.clr = clr; v.wd = wd;
        v.cnt = cnt; v.f = f; v.e = e; v.af = af; v.ae = ae; v.ov = ov; v.ud = ud;
        v.chk_rd = chk_rd; v.rdat = rdat;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic wr, input logic rd, input logic flush, input logic clr,
                         input logic [7:0] wd);
        bus.wr = wr; bus.rd = rd; bus.flush = flush; bus.clr_err = clr; bus.w_data = wd;
    endtask

    // Advance one edge, sample 1 time unit later
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_flags(input string tag, input logic [2:0] cnt, input logic f,
                             input logic e, input logic af, input logic ae, input logic ov,
                             input logic ud);
        chk({tag, ".count"}, 32'(bus.count), 32'(cnt));
        chk({tag, ".full"}, 32'(bus.full), 32'(f));
        chk({tag, ".empty"}, 32'(bus.empty), 32'(e));
        chk({tag, ".almost_full"}, 32'(bus.almost_full), 32'(af));
        chk({tag, ".almost_empty"}, 32'(bus.almost_empty), 32'(ae));
        chk({tag, ".overflow"}, 32'(bus.overflow), 32'(ov));
        chk({tag, ".underflow"}, 32'(bus.underflow), 32'(ud));
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        reset    = 1'b1;
        drive(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);

        //               wr rd fl cl  wd    cnt f  e  af ae ov ud chk rdat
        // Fill to full; r_data stays on the first word
        vecs.push_back(mk(1, 0, 0, 0, 8'h11, 1, 0, 0, 0, 1, 0, 0, 1, 8'h11));
        vecs.push_back(mk(1, 0, 0, 0, 8'h22, 2, 0, 0, 0, 0, 0, 0, 1, 8'h11));
        vecs.push_back(mk(1, 0, 0, 0, 8'h33, 3, 0, 0, 1, 0, 0, 0, 1, 8'h11));
        vecs.push_back(mk(1, 0, 0, 0, 8'h44, 4, 1, 0, 1, 0, 0, 0, 1, 8'h11));
        // Write into full without a pop: rejected, overflow sticks
        vecs.push_back(mk(1, 0, 0, 0, 8'h55, 4, 1, 0, 1, 0, 1, 0, 1, 8'h11));
        vecs.push_back(mk(0, 1, 0, 0, 8'h00, 3, 0, 0, 1, 0, 1, 0, 1, 8'h22));
        vecs.push_back(mk(0, 1, 0, 0, 8'h00, 2, 0, 0, 0, 0, 1, 0, 1, 8'h33));
        vecs.push_back(mk(0, 1, 0, 0, 8'h00, 1, 0, 0, 0, 1, 1, 0, 1, 8'h44));
        vecs.push_back(mk(0, 1, 0, 0, 8'h00, 0, 0, 1, 0, 1, 1, 0, 0, 8'h00));
        vecs.push_back(mk(0, 0, 0, 1, 8'h00, 0, 0, 1, 0, 1, 0, 0, 0, 8'h00));
        // Refill, then simultaneous push/pop while full
        vecs.push_back(mk(1, 0, 0, 0, 8'h11, 1, 0, 0, 0, 1, 0, 0, 1, 8'h11));
        vecs.push_back(mk(1, 0, 0, 0, 8'h22, 2, 0, 0, 0, 0, 0, 0, 1, 8'h11));
        vecs.push_back(mk(1, 0, 0, 0, 8'h33, 3, 0, 0, 1, 0, 0, 0, 1, 8'h11));
        vecs.push_back(mk(1, 0, 0, 0, 8'h44, 4, 1, 0, 1, 0, 0, 0, 1, 8'h11));
        vecs.push_back(mk(1, 1, 0, 0, 8'h66, 4, 1, 0, 1, 0, 0, 0, 1, 8'h22));
        vecs.push_back(mk(0, 1, 0, 0, 8'h00, 3, 0, 0, 1, 0, 0, 0, 1, 8'h33));
        vecs.push_back(mk(0, 1, 0, 0, 8'h00, 2, 0, 0, 0, 0, 0, 0, 1, 8'h44));
        vecs.push_back(mk(0, 1, 0, 0, 8'h00, 1, 0, 0, 0, 1, 0, 0, 1, 8'h66));
        vecs.push_back(mk(0, 1, 0, 0, 8'h00, 0, 0, 1, 0, 1, 0, 0, 0, 8'h00));
        // Push/pop on empty: write only, underflow sets
        vecs.push_back(mk(1, 1, 0, 0, 8'h77, 1, 0, 0, 0, 1, 0, 1, 1, 8'h77));
        vecs.push_back(mk(0, 0, 0, 1, 8'h00, 1, 0, 0, 0, 1, 0, 0, 1, 8'h77));
        vecs.push_back(mk(0, 1, 0, 0, 8'h00, 0, 0, 1, 0, 1, 0, 0, 0, 8'h00));
        // Set beats clear in the same cycle, then a plain clear
        vecs.push_back(mk(0, 1, 0, 1, 8'h00, 0, 0, 1, 0, 1, 0, 1, 0, 8'h00));
        vecs.push_back(mk(0, 0, 0, 1, 8'h00, 0, 0, 1, 0, 1, 0, 0, 0, 8'h00));

        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        #1;
        chk_flags("reset", 3'd0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);

        foreach (vecs[i]) begin
            drive(vecs[i].wr, vecs[i].rd, vecs[i].flush, vecs[i].clr, vecs[i].wd);
            step();
            chk_flags($sformatf("v%0d", i), vecs[i].cnt, vecs[i].f, vecs[i].e, vecs[i].af,
                      vecs[i].ae, vecs[i].ov, vecs[i].ud);
            if (vecs[i].chk_rd) chk($sformatf("v%0d.r_data", i), 32'(bus.r_data),
                                    32'(vecs[i].rdat));
        end

        // Lock-step stream across two pointer wraps
        for (int i = 0; i < 10; i++) begin
            drive(1'b1, (i > 0), 1'b0, 1'b0, 8'(8'hA0 + i));
            step();
            chk($sformatf("stream%0d.r_data", i), 32'(bus.r_data), 32'(8'hA0 + i));
            chk($sformatf("stream%0d.count", i), 32'(bus.count), 32'd1);
        end
        drive(1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
        step();
        chk("stream_end.count", 32'(bus.count), 32'd0);

        // Flush with a concurrent write, then flush with a pop on empty
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 1'b0, 1'b0, 1'b0, 8'(8'hC0 + i));
            step();
        end
        chk("pre_flush.count", 32'(bus.count), 32'd3);
        drive(1'b1, 1'b0, 1'b1, 1'b0, 8'hEE);
        step();
        chk_flags("flush_wr", 3'd0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        drive(1'b0, 1'b1, 1'b1, 1'b0, 8'h00);
        step();
        chk_flags("flush_rd", 3'd0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        drive(1'b1, 1'b0, 1'b0, 1'b0, 8'hD1);
        step();
        chk("post_flush.r_data", 32'(bus.r_data), 32'hD1);

        // Fill further and force overflow, then reset asynchronously mid-cycle
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 1'b0, 1'b0, 1'b0, 8'(8'hE0 + i));
            step();
        end
        chk("pre_reset.overflow", 32'(bus.overflow), 32'd1);
        drive(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
        #1;
        reset = 1'b1;
        #1;
        chk_flags("async_reset", 3'd0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        step();
        reset = 1'b0;
        drive(1'b1, 1'b1, 1'b0, 1'b0, 8'h5A);
        step();
        chk_flags("after_reset", 3'd1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
        chk("after_reset.r_data", 32'(bus.r_data), 32'h5A);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/fifo_level.md
# fifo_level

Parametrised synchronous FIFO with first-word-fall-through read data, an occupancy count, programmable almost-full/almost-empty thresholds, a synchronous flush and sticky overflow/underflow error flags. It replaces the basic full/empty-only FIFO behind the switch/button test harnesses. It is the buffering element between debounced-tick producers/consumers and downstream datapaths that need early back-pressure.

## Interface
- B, 8: data width in bits (≥1)
- W, 4: address bits; depth D = 2^W (≥1)
- AF_LEVEL, 2^W-1: almost_full asserts when count ≥ AF_LEVEL (1 ≤ AF_LEVEL ≤ D)
- AE_LEVEL, 1: almost_empty asserts when count ≤ AE_LEVEL (0 ≤ AE_LEVEL < D)

- clk  in  1  single clock; all state changes on rising edge
- reset  in  1  asynchronous, active-high; clears all state immediately
- wr  in  1  write strobe, one entry per cycle high
- rd  in  1  read strobe; pops head entry
- w_data  in  B  data written when wr accepted
- flush  in  1  synchronous clear of contents
- clr_err  in  1  synchronous clear of sticky error flags
- r_data  out  B  head entry (show-ahead), valid while empty=0
- count  out  W+1  occupancy 0..D
- full  out  1  count == D
- empty  out  1  count == 0
- almost_full  out  1  count ≥ AF_LEVEL
- almost_empty  out  1  count ≤ AE_LEVEL
- overflow  out  1  sticky: wr seen while full and not accepted
- underflow  out  1  sticky: rd seen while empty

## Operation
- Storage: D × B register array, not reset; write pointer and read pointer are W bits, wrap modulo D naturally.
- r_data = array[r_ptr], combinational from registered pointer/array; value is don't-care while empty.
- Accept rules, evaluated on current (pre-edge) state:
  - wr accepted if !full, or if full and rd also high (simultaneous pop frees slot).
  - rd accepted if !empty. rd while empty is ignored, even when wr is high the same cycle.
- Per edge: accepted write stores w_data at w_ptr, w_ptr+1; accepted read does r_ptr+1; count += accepted wr − accepted rd.
- Full & rd & wr: both performed, count stays D, full stays 1, head advances.
- Empty & rd & wr: write only, count → 1, underflow set.
- flush: highest priority besides reset; pointers and count → 0, wr/rd that cycle ignored and raise no errors; overflow/underflow unchanged.
- overflow sets on wr & full & !rd & !flush; underflow sets on rd & empty & !flush. Both hold until clr_err or reset. Set has priority over clr_err in the same cycle.
- All flags (full, empty, almost_*) are registered, computed from next-count, so they change on the same edge as count. No combinational path from inputs to outputs.

## Timing
- Reset values: count 0, empty 1, full 0, almost_empty 1, almost_full 0, overflow 0, underflow 0, pointers 0.
- Write-to-read latency: a word written into an empty FIFO appears on r_data and empty=0 after that edge. It can be popped the next cycle.
- Read: r_data shows the next entry one edge after rd is accepted.
- Throughput: one write and one read per cycle sustained.
- Reset mid-operation: outputs reach reset values asynchronously. First edge after deassertion behaves as for an empty FIFO.
- Pointer wrap: D+1 consecutive writes interleaved with reads must return data in exact order across the wrap boundary.

## Test plan
- B=8, W=2, AF_LEVEL=3, AE_LEVEL=1. After reset, write 0x11,0x22,0x33,0x44:
  - count 1,2,3,4; almost_empty drops at count 2; almost_full rises at count 3; full at 4.
  - r_data stays 0x11 throughout.
- Full FIFO, wr=1 with 0x55, rd=0 → overflow=1, count 4, contents unchanged. Then pop 4 → r_data 0x11,0x22,0x33,0x44, then empty=1.
- Full FIFO, rd=wr=1 with 0x66 → count 4, full 1, r_data 0x22. Draining returns 0x22,0x33,0x44,0x66.
- Empty FIFO, rd=wr=1 with 0x77 → count 1, underflow=1, r_data 0x77. clr_err=1 one cycle → underflow 0.
- 10 writes/reads in lock-step with incrementing data (pointer wraps twice) → every read matches in order, count never exceeds 1.
- count 3, assert flush with wr=1 → count 0, empty 1, no overflow. Assert reset mid-stream → all outputs at reset values before the next edge.
